// File: rtl/encode_6466b.sv
// 64b/66b transmit PCS encoder: pairs 32-bit XGMII half-words into one
// 64-bit word, encodes it as a 66-bit block and emits it as 32-bit halves.
//
// Ports:
//   i_txc             transmit clock, rising edge
//   i_reset_n         asynchronous active-low reset
//   i_txd/i_txctl     XGMII data half-word and per-lane control flags
//   i_tx_data_valid   gearbox pacing; nothing advances while low
//   o_txd             encoded payload half (bits 31:0 first, then 63:32)
//   o_tx_header       sync header, valid with o_tx_header_valid
//   o_tx_header_valid high on the cycle carrying payload bits 31:0
//   o_tx_data_valid   i_tx_data_valid delayed one cycle
//
// Build option: define ENCODER_TX_SM_EN to compile in the Clause 49
// transmit state machine (TX_INIT/TX_C/TX_D/TX_T/TX_E sequencing).

module encode_6466b (
    input  logic        i_txc,
    input  logic        i_reset_n,
    input  logic [31:0] i_txd,
    input  logic [3:0]  i_txctl,
    input  logic        i_tx_data_valid,
    output logic [31:0] o_txd,
    output logic [1:0]  o_tx_header,
    output logic        o_tx_header_valid,
    output logic        o_tx_data_valid
);

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_NBYTES = DATA_WIDTH / 8;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTL  = 2'b01;

    localparam logic [7:0] RS_IDLE  = 8'h07;
    localparam logic [7:0] RS_START = 8'hFB;
    localparam logic [7:0] RS_TERM  = 8'hFD;
    localparam logic [7:0] RS_SEQ   = 8'h9C;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_S0    = 8'h78;
    localparam logic [7:0] BT_S4    = 8'h33;
    localparam logic [7:0] BT_O0    = 8'h4B;
    localparam logic [7:0] BT_O4    = 8'h2D;
    localparam logic [7:0] BT_O0S4  = 8'h66;
    localparam logic [7:0] BT_O0O4  = 8'h55;
    // Terminate types T7..T0, byte k holds the type for T in lane k
    localparam logic [63:0] BT_T_TAB = 64'hFFE1_D2CC_B4AA_9987;

    localparam logic [3:0] O_SEQ = 4'h0;

    // Error block: type 0x1E with every lane coded as error
    localparam logic [63:0] E_BLOCK = {{8{CC_ERROR}}, BT_IDLE};

    typedef enum logic [2:0] {
        CLS_C,
        CLS_S,
        CLS_D,
        CLS_T,
        CLS_E
    } cls_t;

    typedef struct packed {
        cls_t        cls;
        logic [1:0]  hdr;
        logic [63:0] payload;
    } enc_t;

    // Encode one 64-bit word; class E leaves the payload for the
    // output mux to replace with the error block.
    function automatic enc_t encode(
        input logic [63:0] w,
        input logic [7:0]  c
    );
        enc_t             r;
        logic [7:0][7:0]  ln;
        logic [7:0][6:0]  code;
        logic [7:0]       st;
        logic [7:0]       tm;
        logic [7:0]       sq;
        logic [7:0]       cc;
        logic [7:0]       below;
        logic [7:0]       above;
        logic [7:0]       thit;
        logic             lo_c;
        logic             hi_c;
        logic             lo_o;
        logic             hi_o;
        logic             hi_s;
        logic             s0;
        logic [7:0]       bt;

        ln = w;
        for (int i = 0; i < 8; i++) begin
            st[i] = c[i] && (ln[i] == RS_START);
            tm[i] = c[i] && (ln[i] == RS_TERM);
            sq[i] = c[i] && (ln[i] == RS_SEQ);
            cc[i] = c[i] && !st[i] && !tm[i] && !sq[i];
            code[i] = (ln[i] == RS_IDLE) ? CC_IDLE : CC_ERROR;
        end

        // below[k]: lanes 0..k-1 are data; above[k]: lanes k+1..7
        // are plain control characters
        below[0] = 1'b1;
        for (int k = 1; k < 8; k++)
            below[k] = below[k-1] && !c[k-1];
        above[7] = 1'b1;
        for (int k = 6; k >= 0; k--)
            above[k] = above[k+1] && cc[k+1];
        thit = tm & below & above;

        lo_c = &cc[3:0];
        hi_c = &cc[7:4];
        lo_o = sq[0] && !(|c[3:1]);
        hi_o = sq[4] && !(|c[7:5]);
        hi_s = st[4] && !(|c[7:5]);
        s0   = st[0] && !(|c[7:1]);

        r.cls     = CLS_E;
        r.hdr     = SYNC_CTL;
        r.payload = '0;
        bt        = BT_IDLE;

        if (c == 8'h00) begin
            r.cls     = CLS_D;
            r.hdr     = SYNC_DATA;
            r.payload = w;
        end else if ((lo_c || lo_o) && (hi_c || hi_o || hi_s)) begin
            if (lo_c) begin
                for (int i = 0; i < 4; i++)
                    r.payload[8+7*i +: 7] = code[i];
            end else begin
                r.payload[31:8]  = w[31:8];
                r.payload[35:32] = O_SEQ;
            end
            if (hi_c) begin
                for (int i = 4; i < 8; i++)
                    r.payload[8+7*i +: 7] = code[i];
            end else begin
                r.payload[39:36] = hi_o ? O_SEQ : 4'h0;
                r.payload[63:40] = w[63:40];
            end
            if (lo_c)
                bt = hi_c ? BT_IDLE : (hi_o ? BT_O4 : BT_S4);
            else
                bt = hi_c ? BT_O0 : (hi_o ? BT_O0O4 : BT_O0S4);
            r.payload[7:0] = bt;
            r.cls = hi_s ? CLS_S : CLS_C;
        end else if (s0) begin
            r.cls     = CLS_S;
            r.payload = {w[63:8], BT_S0};
        end else if (|thit) begin
            r.cls = CLS_T;
            for (int k = 0; k < 8; k++) begin
                if (thit[k]) begin
                    r.payload[7:0] = BT_T_TAB[8*k +: 8];
                    // data shifts up past the type byte
                    for (int j = 0; j < 7; j++)
                        if (j < k)
                            r.payload[8+8*j +: 8] = ln[j];
                    for (int j = 1; j < 8; j++)
                        if (j > k)
                            r.payload[8+7*j +: 7] = code[j];
                end
            end
        end

        return r;
    endfunction

    logic                   phase;
    logic [DATA_WIDTH-1:0]  held_lower;
    logic [DATA_NBYTES-1:0] held_ctl;
    logic [DATA_WIDTH-1:0]  held_upper;

    enc_t        enc;
    logic [1:0]  blk_hdr;
    logic [63:0] blk_payload;

    always_comb begin
        enc = encode({i_txd, held_lower}, {i_txctl, held_ctl});
    end

`ifdef ENCODER_TX_SM_EN

    // Local fault ordered set: 0x4B, lanes 1-3 = 00 00 01, idle upper
    localparam logic [63:0] LF_BLOCK = 64'h0000_0000_0100_004B;

    typedef enum logic [2:0] {
        TX_INIT,
        TX_C,
        TX_D,
        TX_T,
        TX_E
    } state_t;

    state_t state;
    state_t state_next;

    always_comb begin
        state_next = state;
        unique case (state)
            TX_INIT: begin
                if (enc.cls == CLS_C)
                    state_next = TX_C;
                else if (enc.cls == CLS_S)
                    state_next = TX_D;
            end
            TX_C, TX_T: begin
                if (enc.cls == CLS_C)
                    state_next = TX_C;
                else if (enc.cls == CLS_S)
                    state_next = TX_D;
                else
                    state_next = TX_E;
            end
            TX_D: begin
                if (enc.cls == CLS_D)
                    state_next = TX_D;
                else if (enc.cls == CLS_T)
                    state_next = TX_T;
                else
                    state_next = TX_E;
            end
            TX_E: begin
                if (enc.cls == CLS_D)
                    state_next = TX_D;
                else if (enc.cls == CLS_T)
                    state_next = TX_T;
                else if (enc.cls == CLS_C)
                    state_next = TX_C;
                else if (enc.cls == CLS_S)
                    state_next = TX_D;
            end
            default: state_next = TX_INIT;
        endcase
    end

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= TX_INIT;
        else if (i_tx_data_valid && phase)
            state <= state_next;
    end

    // INIT reports local fault for the word it sees; otherwise the
    // state being entered decides whether the word is replaced by E.
    always_comb begin
        blk_hdr     = enc.hdr;
        blk_payload = enc.payload;
        if (state == TX_INIT) begin
            blk_hdr     = SYNC_CTL;
            blk_payload = LF_BLOCK;
        end else if (state_next == TX_E) begin
            blk_hdr     = SYNC_CTL;
            blk_payload = E_BLOCK;
        end
    end

`else

    always_comb begin
        blk_hdr     = enc.hdr;
        blk_payload = enc.payload;
        if (enc.cls == CLS_E) begin
            blk_hdr     = SYNC_CTL;
            blk_payload = E_BLOCK;
        end
    end

`endif

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase             <= 1'b0;
            held_lower        <= '0;
            held_ctl          <= '0;
            held_upper        <= '0;
            o_txd             <= '0;
            o_tx_header       <= 2'b00;
            o_tx_header_valid <= 1'b0;
            o_tx_data_valid   <= 1'b0;
        end else begin
            o_tx_data_valid <= i_tx_data_valid;
            if (i_tx_data_valid) begin
                phase <= ~phase;
                if (!phase) begin
                    held_lower        <= i_txd;
                    held_ctl          <= i_txctl;
                    o_txd             <= held_upper;
                    o_tx_header_valid <= 1'b0;
                end else begin
                    o_txd             <= blk_payload[31:0];
                    o_tx_header       <= blk_hdr;
                    o_tx_header_valid <= 1'b1;
                    held_upper        <= blk_payload[63:32];
                end
            end else begin
                o_tx_header_valid <= 1'b0;
            end
        end
    end

endmodule
